adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 176 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares a single W-bit adder among NREQ requesters.
// Define ADDER_ARB_SAT_EN to get a two's-complement saturated sum instead of a wrapped one.

module NBitAdder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

module adder_arbiter #(
  parameter int W    = 16,
  parameter int NREQ = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        ip1_bus,
  input  logic [NREQ*W-1:0]        ip2_bus,
  output logic [NREQ-1:0]          gnt,
  output logic [W-1:0]             res,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     busy
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_winner;
  logic [IW-1:0]   cur_id;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    sum;
  logic [W-1:0]    sum_final;
  logic [IW-1:0]   pick;
  logic            grant_en;
  logic            grant;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  // Round-robin search starting one past the previous winner; NREQ is a power of two so the wrap is free.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    logic          found;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last + IW'(i);
      if (!found && r[cand]) begin
        idx   = cand;
        found = 1'b1;
      end else begin
        idx   = idx;
      end
    end
    return idx;
  endfunction

`ifdef ADDER_ARB_SAT_EN
  function automatic logic [W-1:0] sat_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] s);
    logic [W-1:0] result;
    if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) begin
      result = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      result = s;
    end
    return result;
  endfunction
`endif

  NBitAdder #(.W(W)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

`ifdef ADDER_ARB_SAT_EN
  assign sum_final = sat_sum(op_a, op_b, sum);
`else
  assign sum_final = sum;
`endif

  // Grant window: IDLE, or HOLD when the consumer takes the current result this cycle.
  always_comb begin
    pick     = rr_pick(req, last_winner);
    grant_en = 1'b0;
    case (state)
      IDLE:    grant_en = 1'b1;
      HOLD:    grant_en = res_ready;
      EXEC:    grant_en = 1'b0;
      default: grant_en = 1'b0;
    endcase
    grant = grant_en && (|req) && !RST;
    if (grant) begin
      gnt = {{(NREQ-1){1'b0}}, 1'b1} << pick;
    end else begin
      gnt = {NREQ{1'b0}};
    end
    sel_a = ip1_bus[pick*W +: W];
    sel_b = ip2_bus[pick*W +: W];
  end

  // Main FSM: capture the winner's operands on grant, register the sum one cycle later, hold until taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      last_winner <= IW'(NREQ - 1);
      cur_id      <= {IW{1'b0}};
      op_a        <= {W{1'b0}};
      op_b        <= {W{1'b0}};
      res         <= {W{1'b0}};
      res_id      <= {IW{1'b0}};
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_a        <= sel_a;
            op_b        <= sel_b;
            cur_id      <= pick;
            last_winner <= pick;
            state       <= EXEC;
            busy        <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        EXEC: begin
          res       <= sum_final;
          res_id    <= cur_id;
          res_valid <= 1'b1;
          state     <= HOLD;
          busy      <= 1'b1;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (grant) begin
              op_a        <= sel_a;
              op_b        <= sel_b;
              cur_id      <= pick;
              last_winner <= pick;
              state       <= EXEC;
              busy        <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            state <= HOLD;
            busy  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (W=16, NREQ=4).
// Expectations follow ADDER_ARB_SAT_EN when the bench is built with that macro.

module tb_adder_arbiter;
  logic        CLK;
  logic        RST;
  logic [3:0]  req;
  logic [63:0] ip1_bus;
  logic [63:0] ip2_bus;
  logic [3:0]  gnt;
  logic [15:0] res;
  logic [1:0]  res_id;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  logic [15:0] a_v [4];
  logic [15:0] b_v [4];
  logic [15:0] sum_v [4];
  int n_assert;
  int n_fail;

  assign ip1_bus = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign ip2_bus = {b_v[3], b_v[2], b_v[1], b_v[0]};

  adder_arbiter #(.W(16), .NREQ(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .ip1_bus   (ip1_bus),
    .ip2_bus   (ip2_bus),
    .gnt       (gnt),
    .res       (res),
    .res_id    (res_id),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    RST = 1'b1;
    req = 4'b1111;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 16'h0000;
      b_v[i] = 16'h0000;
    end
    #2;
    // Reset state, with requests already asserted
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_res", 32'(res), 32'h0);
    chk("rst_id", 32'(res_id), 32'h0);
    req = 4'b0000;
    step();
    RST = 1'b0;

    // Single request
    a_v[0] = 16'h0003;
    b_v[0] = 16'h0004;
    req = 4'b0001;
    #1;
    chk("single_gnt", 32'(gnt), 32'h1);
    step();
    req = 4'b0000;
    chk("single_exec_busy", 32'(busy), 32'h1);
    chk("single_exec_gnt", 32'(gnt), 32'h0);
    chk("single_exec_valid", 32'(res_valid), 32'h0);
    step();
    chk("single_res", 32'(res), 32'h7);
    chk("single_id", 32'(res_id), 32'h0);
    chk("single_valid", 32'(res_valid), 32'h1);
    step();
    chk("single_idle_valid", 32'(res_valid), 32'h0);
    chk("single_idle_busy", 32'(busy), 32'h0);

    // Round-robin after a fresh reset: requester 0 first
    RST = 1'b1;
    #2;
    RST = 1'b0;
    a_v[0] = 16'h1111; b_v[0] = 16'h0001; sum_v[0] = 16'h1112;
    a_v[1] = 16'h2222; b_v[1] = 16'h0002; sum_v[1] = 16'h2224;
    a_v[2] = 16'h3333; b_v[2] = 16'h0003; sum_v[2] = 16'h3336;
    a_v[3] = 16'hF000; b_v[3] = 16'h2000; sum_v[3] = 16'h1000;
    req = 4'b1111;
    #1;
    chk("rr_first_gnt", 32'(gnt), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr%0d_exec_gnt", k), 32'(gnt), 32'h0);
      step();
      if (k == 4) req = 4'b0000;
      #1;
      chk($sformatf("rr%0d_id", k), 32'(res_id), 32'(k % 4));
      chk($sformatf("rr%0d_res", k), 32'(res), 32'(sum_v[k % 4]));
      chk($sformatf("rr%0d_valid", k), 32'(res_valid), 32'h1);
      if (k < 4) chk($sformatf("rr%0d_next_gnt", k), 32'(gnt), 32'(4'b0001 << ((k + 1) % 4)));
      else       chk("rr_last_gnt", 32'(gnt), 32'h0);
    end
    step();
    chk("rr_idle_busy", 32'(busy), 32'h0);

    // Backpressure
    res_ready = 1'b0;
    req = 4'b0010;
    #1;
    chk("bp_gnt", 32'(gnt), 32'h2);
    step();
    req = 4'b0100;
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_res", c), 32'(res), 32'h2224);
      chk($sformatf("bp%0d_id", c), 32'(res_id), 32'h1);
      chk($sformatf("bp%0d_valid", c), 32'(res_valid), 32'h1);
      chk($sformatf("bp%0d_gnt", c), 32'(gnt), 32'h0);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_gnt", 32'(gnt), 32'h4);
    step();
    req = 4'b0000;
    chk("bp_exec_valid", 32'(res_valid), 32'h0);
    chk("bp_exec_busy", 32'(busy), 32'h1);
    step();
    chk("bp_res", 32'(res), 32'h3336);
    chk("bp_id", 32'(res_id), 32'h2);
    step();

    // Overflow cases on requester 3
    a_v[3] = 16'h7FFF; b_v[3] = 16'h0001;
    req = 4'b1000;
    #1;
    chk("ovf_pos_gnt", 32'(gnt), 32'h8);
    step();
    req = 4'b0000;
    step();
`ifdef ADDER_ARB_SAT_EN
    chk("ovf_pos_res", 32'(res), 32'h7FFF);
`else
    chk("ovf_pos_res", 32'(res), 32'h8000);
`endif
    a_v[3] = 16'h8000; b_v[3] = 16'hFFFF;
    req = 4'b1000;
    #1;
    chk("ovf_neg_gnt_in_hold", 32'(gnt), 32'h8);
    step();
    req = 4'b0000;
    step();
`ifdef ADDER_ARB_SAT_EN
    chk("ovf_neg_res", 32'(res), 32'h8000);
`else
    chk("ovf_neg_res", 32'(res), 32'h7FFF);
`endif
    step();

    // Reset during EXEC discards the in-flight result
    req = 4'b0001;
    step();
    req = 4'b0000;
    chk("abort_exec_busy", 32'(busy), 32'h1);
    RST = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_valid", 32'(res_valid), 32'h0);
    chk("abort_gnt", 32'(gnt), 32'h0);
    #1;
    RST = 1'b0;
    step();
    chk("abort_post1_valid", 32'(res_valid), 32'h0);
    step();
    chk("abort_post2_valid", 32'(res_valid), 32'h0);
    req = 4'b1000;
    #1;
    chk("abort_next_gnt", 32'(gnt), 32'h8);
    step();
    req = 4'b0000;
    step();
    chk("abort_next_id", 32'(res_id), 32'h3);
    chk("abort_next_valid", 32'(res_valid), 32'h1);
`ifdef ADDER_ARB_SAT_EN
    chk("abort_next_res", 32'(res), 32'h8000);
`else
    chk("abort_next_res", 32'(res), 32'h7FFF);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
